icache_fill: RTL and testbench
==============================

# icache_fill

Line-fill engine directly upstream of the instruction cache. On an icache miss (`pull`), it reads one cache line from external quad-SPI memory, buffering the whole line as it arrives. It then streams the line into the icache as an unbroken burst of nibble strobes (`dread`/`wstrobe_d`). While a fill is in progress it drives `busy`, and the fetch stage holds its address stable for as long as `busy` is high.

## Interface
- `LINE_LENGTH`, 4: cache line size in bytes; a line is LINE_LENGTH*2 nibbles.
- `PA`, 22: physical byte-address width.
- `CMD`, 8'hEB: quad read command, sent as 2 nibbles on the quad lines.
- `DUMMY`, 4: dummy nibble-times between address and data.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pull`  in  1  miss request from the icache.
- `tag`  in  PA-log2(LINE_LENGTH)  line address from the icache; sampled only at start.
- `abort`  in  1  fetch redirect; cancels a fill that has not reached delivery.
- `busy`  out  1  fill in progress.
- `dread`  out  4  nibble to the icache.
- `wstrobe_d`  out  1  `dread` valid; asserted on LINE_LENGTH*2 consecutive cycles per fill.
- `spi_cs_n`  out  1  chip select.
- `spi_sclk`  out  1  serial clock, clk/2.
- `spi_oe`  out  1  drive enable for `spi_out`.
- `spi_out`  out  4  quad output data.
- `spi_in`  in  4  quad input data.

## Operation
- States: IDLE, CMD (2 nibbles), ADDR (6 nibbles), DUMMY (DUMMY nibbles), DATA (LINE_LENGTH*2 nibbles), DELIVER (LINE_LENGTH*2 cycles).
- IDLE: on `pull && !abort`, latch `tag` and go to CMD. `busy` rises the next cycle.
- Address is 24 bits: {(24-PA) zeros, tag, log2(LINE_LENGTH) zeros}, sent MSB nibble first.
- CMD and ADDR: `spi_oe`=1. DUMMY and DATA: `spi_oe`=0, `spi_out`=0.
- DATA: each sampled nibble shifts into a LINE_LENGTH*8-bit line buffer in arrival order.
- DELIVER: `cs_n`=1 and `sclk`=0. Emit buffer nibbles in arrival order, one per cycle, with `wstrobe_d`=1 continuously. The icache counter requires the strobes to be unbroken.
- After the last strobe, go to IDLE and drop `busy`.
- `abort` in CMD/ADDR/DUMMY/DATA: next cycle `cs_n`=1, `sclk`=0, `oe`=0, state IDLE, `busy`=0, no strobes issued.
- `abort` in DELIVER is ignored and the burst completes.
- `pull` while busy is ignored.
- `pull` and `abort` together in IDLE: abort wins and no fill starts.

## Timing
- Nibble period is 2 clk, tracked by phase bit `ph`.
  - `ph`=0: `sclk`=0 and `spi_out` updates.
  - `ph`=1: `sclk`=1.
  - `spi_in` is sampled at the edge ending `ph`=1.
- `cs_n` goes low on the same cycle as the first `ph`=0 of CMD.
- Latency, `pull` sampled at edge t0, defaults:
  - t1..t40: CMD+ADDR+DUMMY+DATA (20 nibbles x 2 clk).
  - t40: `cs_n` still low. t41: `cs_n` high.
  - t41..t48: `wstrobe_d`=1.
  - t49: `busy`=0 and IDLE, so a new `pull` can be accepted at edge t49.
- Back-to-back fills: the minimum `cs_n` high time is LINE_LENGTH*2+1 cycles.
- Reset values: `busy`=0, `dread`=0, `wstrobe_d`=0, `spi_cs_n`=1, `spi_sclk`=0, `spi_oe`=0, `spi_out`=0, state IDLE, buffer and counters 0.
- Asserting `reset` mid-fill or mid-delivery forces the reset values immediately (asynchronous), with no further strobes.
- Nibble counters wrap only by state exit, never by overflow. Counter width is log2(max(6, DUMMY, LINE_LENGTH*2))+1.

## Structure
- Shared package `vc16_pkg` holds:
  - the fill state enum;
  - the `ADDR_NIBBLES`=6 and `CMD_NIBBLES`=2 constants;
  - the 24-bit address-width constant.
- One sub-module, `qspi_phy`: `ph` toggle, `sclk`/`cs_n`/`oe`/`spi_out` output registers, and the `spi_in` sample strobe.
  - It takes `active` and `tx_nibble` and returns `rx_nibble`/`rx_valid`/`nib_done`.
- The FSM, counters and line buffer stay in `icache_fill`.

## Test plan
- `tag`=0x48D, `pull` at t0, `spi_in` returns 1..8 in DATA:
  - `spi_out` nibbles E,B,0,0,1,2,3,4 with `oe`=1 during CMD+ADDR;
  - `dread`=1,2,...,8 on t41..t48 with `wstrobe_d` unbroken;
  - `busy`=0 at t49.
- `abort` during DUMMY: `cs_n`=1, `busy`=0 the next cycle; `wstrobe_d` never asserts.
- `abort` at t43 (DELIVER): strobes t41..t48 still complete with correct data.
- `pull` and `abort` in the same IDLE cycle: `cs_n` stays 1 and `busy` stays 0.
- `pull` held high through a fill with `tag` changing mid-fill: the address uses the tag latched at t0, and the second fill's `cs_n` falls at t50.
- `reset` low during DATA: all outputs take reset values asynchronously. After release, a new `pull` completes a normal fill.

Source files
------------

// File: rtl/vc16_pkg.sv
// Shared types and constants for the instruction-side quad-SPI line fill.
package vc16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DELIVER
  } fill_state_e;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;
  localparam int ADDR_W       = 24;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qspi_phy.sv
// Quad-SPI pin driver: nibble phase toggle, registered pin outputs and input sample strobe.
module qspi_phy (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       tx_oe,
  input  logic [3:0] tx_nibble,
  input  logic [3:0] spi_in,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_oe,
  output logic [3:0] spi_out,
  output logic [3:0] rx_nibble,
  output logic       rx_valid,
  output logic       nib_done
);

  logic ph;
  logic ph_n;

  // A freshly selected link always starts on the low half of a nibble.
  assign ph_n = spi_cs_n ? 1'b0 : ~ph;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph       <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_oe   <= 1'b0;
      spi_out  <= 4'h0;
    end else if (!active) begin
      ph       <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_oe   <= 1'b0;
      spi_out  <= 4'h0;
    end else begin
      ph       <= ph_n;
      spi_cs_n <= 1'b0;
      spi_sclk <= ph_n;
      if (!ph_n) begin
        spi_out <= tx_oe ? tx_nibble : 4'h0;
        spi_oe  <= tx_oe;
      end
    end
  end

  assign nib_done  = ~spi_cs_n & ph;
  assign rx_valid  = nib_done & ~spi_oe;
  assign rx_nibble = spi_in;

endmodule

// File: rtl/icache_fill.sv
// Icache miss line-fill engine: quad-SPI read of one line, then an unbroken nibble burst.
module icache_fill
  import vc16_pkg::*;
#(
  parameter int         LINE_LENGTH = 4,
  parameter int         PA          = 22,
  parameter logic [7:0] CMD         = 8'hEB,
  parameter int         DUMMY       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   tag,
  input  logic                                abort,
  output logic                                busy,
  output logic [3:0]                          dread,
  output logic                                wstrobe_d,
  output logic                                spi_cs_n,
  output logic                                spi_sclk,
  output logic                                spi_oe,
  output logic [3:0]                          spi_out,
  input  logic [3:0]                          spi_in,
  output fill_state_e                         state_dbg
);

  localparam int TAG_W = PA - $clog2(LINE_LENGTH);
  localparam int NIBS  = LINE_LENGTH * 2;
  localparam int LB_W  = LINE_LENGTH * 8;
  localparam int CNT_W = $clog2(max3(ADDR_NIBBLES, DUMMY, NIBS)) + 1;

  // Request handshake: pull is a one-cycle-sampled request taken only in IDLE
  // (and only without abort); busy is the acknowledgement and stays high until
  // the last wstrobe_d, during which the requester must keep tag stable.
  fill_state_e        state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [TAG_W-1:0]   tag_q, tag_next;
  logic [LB_W-1:0]    line_buf;

  logic               link_active;
  logic               tx_oe;
  logic [3:0]         tx_nibble;
  logic [ADDR_W-1:0]  addr_next;
  logic [ADDR_W-1:0]  addr_sh;
  logic [7:0]         cmd_sh;
  logic [3:0]         rx_nibble;
  logic               rx_valid;
  logic               nib_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tag_q    <= '0;
      line_buf <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      tag_q <= tag_next;
      if (state == ST_DATA && rx_valid) begin
        line_buf <= {line_buf[LB_W-5:0], rx_nibble};
      end else if (state == ST_DELIVER) begin
        line_buf <= {line_buf[LB_W-5:0], 4'h0};
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tag_next   = tag_q;
    case (state)
      ST_IDLE: begin
        if (pull && !abort) begin
          state_next = ST_CMD;
          cnt_next   = '0;
          tag_next   = tag;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (abort) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (nib_done) begin
          cnt_next = cnt + 1'b1;
          if (state == ST_CMD && cnt == CNT_W'(CMD_NIBBLES - 1)) begin
            state_next = ST_ADDR;
            cnt_next   = '0;
          end else if (state == ST_ADDR && cnt == CNT_W'(ADDR_NIBBLES - 1)) begin
            state_next = ST_DUMMY;
            cnt_next   = '0;
          end else if (state == ST_DUMMY && cnt == CNT_W'(DUMMY - 1)) begin
            state_next = ST_DATA;
            cnt_next   = '0;
          end else if (state == ST_DATA && cnt == CNT_W'(NIBS - 1)) begin
            state_next = ST_DELIVER;
            cnt_next   = '0;
          end
        end
      end
      ST_DELIVER: begin
        if (cnt == CNT_W'(NIBS - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The phy registers its pins, so it is fed the nibble for the upcoming cycle.
  always_comb begin
    link_active = 1'b0;
    tx_oe       = 1'b0;
    tx_nibble   = 4'h0;
    addr_next   = ADDR_W'(tag_next) << $clog2(LINE_LENGTH);
    addr_sh     = addr_next << {cnt_next, 2'b00};
    cmd_sh      = CMD << {cnt_next[0], 2'b00};
    case (state_next)
      ST_CMD: begin
        link_active = 1'b1;
        tx_oe       = 1'b1;
        tx_nibble   = cmd_sh[7:4];
      end
      ST_ADDR: begin
        link_active = 1'b1;
        tx_oe       = 1'b1;
        tx_nibble   = addr_sh[ADDR_W-1 -: 4];
      end
      ST_DUMMY, ST_DATA: begin
        link_active = 1'b1;
      end
      default: begin
        link_active = 1'b0;
      end
    endcase
  end

  qspi_phy u_phy (
    .clk       (clk),
    .reset     (reset),
    .active    (link_active),
    .tx_oe     (tx_oe),
    .tx_nibble (tx_nibble),
    .spi_in    (spi_in),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_oe    (spi_oe),
    .spi_out   (spi_out),
    .rx_nibble (rx_nibble),
    .rx_valid  (rx_valid),
    .nib_done  (nib_done)
  );

  assign busy      = (state != ST_IDLE);
  assign wstrobe_d = (state == ST_DELIVER);
  assign dread     = (state == ST_DELIVER) ? line_buf[LB_W-1 -: 4] : 4'h0;
  assign state_dbg = state;

endmodule

// File: tb/tb_icache_fill.sv
// Bench for icache_fill: cycle-by-cycle reference of the fill timeline against randomized data.
module tb_icache_fill;
  import vc16_pkg::*;

  logic        clk;
  logic        reset;
  logic        pull;
  logic [19:0] tag;
  logic        abort;
  logic        busy;
  logic [3:0]  dread;
  logic        wstrobe_d;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_oe;
  logic [3:0]  spi_out;
  logic [3:0]  spi_in;
  fill_state_e state_dbg;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  icache_fill dut (
    .clk       (clk),
    .reset     (reset),
    .pull      (pull),
    .tag       (tag),
    .abort     (abort),
    .busy      (busy),
    .dread     (dread),
    .wstrobe_d (wstrobe_d),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_oe    (spi_oe),
    .spi_out   (spi_out),
    .spi_in    (spi_in),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp_v);
    end
  endtask

  task automatic chk_reset_values(input string tag_s);
    chk({tag_s, " busy"},      8'(busy),      8'h0);
    chk({tag_s, " dread"},     8'(dread),     8'h0);
    chk({tag_s, " wstrobe_d"}, 8'(wstrobe_d), 8'h0);
    chk({tag_s, " cs_n"},      8'(spi_cs_n),  8'h1);
    chk({tag_s, " sclk"},      8'(spi_sclk),  8'h0);
    chk({tag_s, " oe"},        8'(spi_oe),    8'h0);
    chk({tag_s, " spi_out"},   8'(spi_out),   8'h0);
  endtask

  // One fill seen as a 49-cycle timeline after the edge that samples pull.
  // Cycle k lies between edge k-1 and edge k; outputs are checked mid-cycle.
  task automatic run_fill(input logic [19:0] t, input int abort_k, input int reset_k,
                          input bit directed, input bit hold, input logic [19:0] tag2);
    logic [31:0] word;
    logic [3:0]  e_out;
    logic [3:0]  exp_d;
    bit          dead;
    bit          act;
    bit          dlv;
    int          di;
    exp_q.delete();
    dead  = 1'b0;
    di    = 0;
    word  = {8'hEB, 2'b00, t, 2'b00};
    pull  = 1'b1;
    tag   = t;
    abort = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      if (!hold) pull = 1'b0;
      if (hold && k == 5) tag = tag2;
      abort = (k == abort_k);
      e_out = (k <= 16) ? word[31 - 4 * ((k - 1) / 2) -: 4] : 4'h0;
      act   = !dead && k <= 40;
      dlv   = !dead && k >= 41 && k <= 48;
      chk($sformatf("cs_n@t%0d", k),    8'(spi_cs_n),  8'(!act));
      chk($sformatf("sclk@t%0d", k),    8'(spi_sclk),  8'(act && (k % 2 == 0)));
      chk($sformatf("oe@t%0d", k),      8'(spi_oe),    8'(act && k <= 16));
      chk($sformatf("spi_out@t%0d", k), 8'(spi_out),   8'(act ? e_out : 4'h0));
      chk($sformatf("busy@t%0d", k),    8'(busy),      8'(!dead && k <= 48));
      chk($sformatf("wstrobe@t%0d", k), 8'(wstrobe_d), 8'(dlv));
      if (dlv) begin
        exp_d = exp_q.pop_front();
        chk($sformatf("dread@t%0d", k), 8'(dread), 8'(exp_d));
      end
      spi_in = 4'($urandom);
      if (k % 2 == 0 && k >= 26 && k <= 40) begin
        if (directed) spi_in = 4'(di + 1);
        exp_q.push_back(spi_in);
        di++;
      end
      if (k == abort_k && k <= 40) dead = 1'b1;
      if (k == reset_k) begin
        reset = 1'b0;
        #1;
        chk_reset_values($sformatf("async_reset@t%0d", k));
        @(posedge clk);
        #1;
        chk_reset_values("held_reset");
        @(negedge clk);
        reset = 1'b1;
        pull  = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    pull   = 1'b0;
    abort  = 1'b0;
    tag    = '0;
    spi_in = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    chk("reset state", 8'(state_dbg), 8'(ST_IDLE));
    reset = 1'b1;
    @(negedge clk);

    // Directed line: tag 0x48D, data nibbles 1..8.
    run_fill(20'h48D, 0, 0, 1'b1, 1'b0, 20'h0);
    for (int i = 0; i < 4; i++) run_fill(20'($urandom), 0, 0, 1'b0, 1'b0, 20'h0);

    // Abort in DUMMY, then abort during DELIVER (ignored).
    run_fill(20'($urandom), 19, 0, 1'b0, 1'b0, 20'h0);
    run_fill(20'($urandom), 43, 0, 1'b0, 1'b0, 20'h0);

    // pull and abort in the same IDLE cycle.
    pull  = 1'b1;
    abort = 1'b1;
    tag   = 20'($urandom);
    @(posedge clk);
    @(negedge clk);
    pull  = 1'b0;
    abort = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("pull_abort cs_n %0d", j), 8'(spi_cs_n), 8'h1);
      chk($sformatf("pull_abort busy %0d", j), 8'(busy),     8'h0);
      @(negedge clk);
    end

    // pull held through a fill with tag changing mid-fill; second fill is back-to-back.
    run_fill(20'hABCDE, 0, 0, 1'b0, 1'b1, 20'h12345);
    run_fill(20'h12345, 0, 0, 1'b0, 1'b0, 20'h0);

    // Reset during DATA, then a normal fill.
    run_fill(20'($urandom), 0, 30, 1'b0, 1'b0, 20'h0);
    run_fill(20'($urandom), 0, 0, 1'b0, 1'b0, 20'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
